uart_cmd_responder: RTL and testbench
=====================================

// Module: uart_cmd_responder
// PURPOSE
//  Command responder at the far end of the framed-string UART link: consumes decoded payloads
//  (rx_string/rx_length/rx_done), parses ASCII register commands, drives a 32-bit register bus,
//  and hands a reply payload to the framed-string transmitter (tx_string/tx_length/tx_req).
//  One command in flight; sits between the UART string handler and the fabric register map.
// PARAMETERS
//  NUM_REGS        16          implemented registers; addresses >= NUM_REGS rejected
//  TX_TIMEOUT_CLKS 2_000_000   max clocks from tx_req to tx_done before abort
// PORTS
//  sys_clk      in   1     system clock
//  sys_rst_n    in   1     reset: asynchronous, active-low
//  rx_string    in   1024  payload, byte k at [8k+7:8k], byte 0 = first char
//  rx_length    in   8     payload byte count
//  rx_done      in   1     1-cycle pulse: rx_string/rx_length valid
//  tx_string    out  1024  reply payload, same byte order; stable from tx_req to tx_done
//  tx_length    out  8     reply byte count
//  tx_req       out  1     1-cycle send request
//  tx_busy      in   1     transmitter busy
//  tx_done      in   1     1-cycle pulse: reply fully sent
//  reg_addr     out  8     register address
//  reg_wr_en    out  1     1-cycle write strobe
//  reg_wr_data  out  32    write data
//  reg_rd_en    out  1     1-cycle read strobe
//  reg_rd_data  in   32    read data, valid exactly 1 clock after reg_rd_en
//  busy         out  1     state != IDLE
//  drop_cnt     out  8     commands dropped while busy; saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, tx_string 0, state IDLE.
//  Commands (hex digits 0-9/A-F/a-f, MSB first):
//   "Waadddddddd" (len 11) -> reg write, reply "OK" (2)
//   "Raa"         (len 3)  -> reg read,  reply "D"+8 uppercase hex (9)
//   anything else, bad hex, wrong length, aa >= NUM_REGS -> no bus access, reply "ER" (2)
//  FSM: IDLE -> LATCH -> PARSE -> EXEC -> [RD_WAIT] -> BUILD -> SEND -> WAIT_DONE -> IDLE
//   IDLE: rx_done -> capture bytes 0..10 and rx_length (bytes beyond 10 ignored).
//   PARSE: one char per clock, accumulate addr/data nibbles, set err flag on invalid char.
//   EXEC: one cycle; write: reg_wr_en=1 with addr/data; read: reg_rd_en=1; err: no strobe.
//   RD_WAIT: one cycle; capture reg_rd_data.
//   BUILD: load tx_string/tx_length (unused bytes 0).
//   SEND: wait tx_busy==0, then tx_req=1 one cycle -> WAIT_DONE.
//   WAIT_DONE: tx_done -> IDLE; timeout counter hits TX_TIMEOUT_CLKS -> IDLE (reply abandoned).
//  rx_done while busy: command dropped, drop_cnt+1 (saturating), no other effect.
//  rx_done coincident with tx_done in WAIT_DONE: dropped (still busy that cycle).
//  rx_length 0: reply "ER".  Strobes never overlap; one strobe max per command.
//  Reset mid-operation: strobes/tx_req deassert immediately, nothing resumed.
// CONFIGURATION
//  UART_CMD_PING_EN defined: "P" (len 1) -> reply "PONG" (4), no bus access.
//  Not defined: "P" -> "ER". No other difference.
// STRUCTURE
//  Package uart_cmd_pkg: state encodings, ASCII constants ('W','R','P','O','K','D','E'),
//   reply lengths, functions hex2nib (with valid flag) and nib2hex (uppercase).
//  Sub-module ascii_hex_nibble: combinational char<->nibble conversion used by PARSE/BUILD.
//  Timeout counter: 21 bits min for default; width from $clog2(TX_TIMEOUT_CLKS+1).
// TESTING
//  "W0312345678" -> reg_wr_en 1 cycle, addr 0x03, data 0x12345678; reply "OK", tx_length 2
//  "R03", reg_rd_data=0xDEADBEEF next clk -> reply "DDEADBEEF", tx_length 9
//  "R10" (NUM_REGS=16), "W0G00000000", "X", len 0 -> no strobes, reply "ER" each
//  Second rx_done during WAIT_DONE -> dropped, drop_cnt 1; 256 drops -> drop_cnt stays 255
//  tx_busy held 1 for 500 clks -> tx_req waits, issued the cycle after busy falls; never tx_done
//   -> return IDLE after TX_TIMEOUT_CLKS
//  "P" -> "PONG" with UART_CMD_PING_EN, "ER" without; reset mid-PARSE -> all outputs 0

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - state/command encodings, ASCII constants and hex helpers for uart_cmd_responder
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LATCH, ST_PARSE, ST_EXEC, ST_RD_WAIT, ST_BUILD, ST_SEND, ST_WAIT_DONE
  } state_t;

  typedef enum logic [1:0] {CMD_ERR, CMD_WR, CMD_RD, CMD_PING} cmd_t;

  localparam logic [7:0] ASC_W = 8'h57;
  localparam logic [7:0] ASC_R = 8'h52;
  localparam logic [7:0] ASC_P = 8'h50;
  localparam logic [7:0] ASC_O = 8'h4F;
  localparam logic [7:0] ASC_K = 8'h4B;
  localparam logic [7:0] ASC_D = 8'h44;
  localparam logic [7:0] ASC_E = 8'h45;
  localparam logic [7:0] ASC_N = 8'h4E;
  localparam logic [7:0] ASC_G = 8'h47;

  localparam logic [7:0] LEN_WR_CMD   = 8'd11;
  localparam logic [7:0] LEN_RD_CMD   = 8'd3;
  localparam logic [7:0] LEN_PING_CMD = 8'd1;
  localparam logic [7:0] LEN_OK       = 8'd2;
  localparam logic [7:0] LEN_ER       = 8'd2;
  localparam logic [7:0] LEN_DATA     = 8'd9;
  localparam logic [7:0] LEN_PONG     = 8'd4;

  // Returns {valid, nibble}; letters A-F/a-f share low bits 1..6 so add 9.
  function automatic logic [4:0] hex2nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
  endfunction

endpackage

// File: rtl/ascii_hex_nibble.sv
// rtl/ascii_hex_nibble.sv - combinational ASCII char -> nibble decode and 32-bit word -> 8 uppercase hex chars
module ascii_hex_nibble
  import uart_cmd_pkg::*;
(
  input  logic [7:0]  char_in,
  output logic [3:0]  nib_out,
  output logic        nib_valid,
  input  logic [31:0] word_in,
  output logic [63:0] hex_out
);

  // hex_out byte 0 carries the most significant nibble so it goes on the wire first
  always_comb begin
    {nib_valid, nib_out} = hex2nib(char_in);
    hex_out = '0;
    for (int i = 0; i < 8; i++)
      hex_out[8*i +: 8] = nib2hex(word_in[28-4*i +: 4]);
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - parses ASCII W/R register commands from the string link and replies OK/D<hex>/ER
// Define UART_CMD_PING_EN to also answer "P" with "PONG".
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS        = 16,
  parameter int TX_TIMEOUT_CLKS = 2_000_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [1023:0] rx_string,
  input  logic [7:0]    rx_length,
  input  logic          rx_done,
  output logic [1023:0] tx_string,
  output logic [7:0]    tx_length,
  output logic          tx_req,
  input  logic          tx_busy,
  input  logic          tx_done,
  output logic [7:0]    reg_addr,
  output logic          reg_wr_en,
  output logic [31:0]   reg_wr_data,
  output logic          reg_rd_en,
  input  logic [31:0]   reg_rd_data,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  localparam int TMO_W = $clog2(TX_TIMEOUT_CLKS + 1);
`ifdef UART_CMD_PING_EN
  localparam bit PING_EN = 1'b1;
`else
  localparam bit PING_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  cmd_t             cmd_kind, kind_dec;
  logic [7:0]       cmd_buf [0:10];
  logic [7:0]       cmd_len;
  logic [3:0]       idx, idx_last;
  logic [7:0]       addr_q;
  logic [31:0]      data_q, rd_q;
  logic             err_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       cur_nib;
  logic             cur_valid, addr_ok, tmo_hit, is_hex_cmd;
  logic [63:0]      rd_hex;
  logic             unused_rx;

  assign unused_rx   = ^rx_string[1023:88];
  assign is_hex_cmd  = (cmd_kind == CMD_WR) || (cmd_kind == CMD_RD);
  assign addr_ok     = ({24'd0, addr_q} < 32'(NUM_REGS));
  assign tmo_hit     = (tmo_cnt == TMO_W'(TX_TIMEOUT_CLKS - 1));
  assign busy        = (state != ST_IDLE);
  assign reg_addr    = addr_q;
  assign reg_wr_data = data_q;
  assign reg_wr_en   = (state == ST_EXEC) && (cmd_kind == CMD_WR) && !err_q && addr_ok;
  assign reg_rd_en   = (state == ST_EXEC) && (cmd_kind == CMD_RD) && !err_q && addr_ok;
  assign tx_req      = (state == ST_SEND) && !tx_busy;

  ascii_hex_nibble u_hex (
    .char_in   (cmd_buf[idx]),
    .nib_out   (cur_nib),
    .nib_valid (cur_valid),
    .word_in   (rd_q),
    .hex_out   (rd_hex)
  );

  always_comb begin
    kind_dec = CMD_ERR;
    if (cmd_len == LEN_WR_CMD && cmd_buf[0] == ASC_W)
      kind_dec = CMD_WR;
    else if (cmd_len == LEN_RD_CMD && cmd_buf[0] == ASC_R)
      kind_dec = CMD_RD;
    else if (PING_EN && cmd_len == LEN_PING_CMD && cmd_buf[0] == ASC_P)
      kind_dec = CMD_PING;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (rx_done) state_nxt = ST_LATCH;
      ST_LATCH:     state_nxt = ST_PARSE;
      ST_PARSE:     if (!is_hex_cmd || idx == idx_last) state_nxt = ST_EXEC;
      ST_EXEC:      state_nxt = reg_rd_en ? ST_RD_WAIT : ST_BUILD;
      ST_RD_WAIT:   state_nxt = ST_BUILD;
      ST_BUILD:     state_nxt = ST_SEND;
      ST_SEND:      if (!tx_busy) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_done || tmo_hit) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      cmd_kind  <= CMD_ERR;
      for (int k = 0; k < 11; k++) cmd_buf[k] <= '0;
      cmd_len   <= '0;
      idx       <= '0;
      idx_last  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      tmo_cnt   <= '0;
      tx_string <= '0;
      tx_length <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (rx_done && state != ST_IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      case (state)
        ST_IDLE: if (rx_done) begin
          for (int k = 0; k < 11; k++) cmd_buf[k] <= rx_string[8*k +: 8];
          cmd_len <= rx_length;
        end
        ST_LATCH: begin
          cmd_kind <= kind_dec;
          idx      <= 4'd1;
          idx_last <= (kind_dec == CMD_WR) ? 4'd10 : 4'd2;
          err_q    <= 1'b0;
          addr_q   <= '0;
          data_q   <= '0;
        end
        // chars 1-2 are the address, chars 3-10 the write data, both MSB first
        ST_PARSE: if (is_hex_cmd) begin
          idx   <= idx + 4'd1;
          err_q <= err_q | ~cur_valid;
          if (idx <= 4'd2) addr_q <= {addr_q[3:0], cur_nib};
          else             data_q <= {data_q[27:0], cur_nib};
        end
        ST_EXEC:    err_q <= err_q | ~addr_ok;
        ST_RD_WAIT: rd_q  <= reg_rd_data;
        ST_BUILD: begin
          tx_string <= '0;
          if (err_q || cmd_kind == CMD_ERR) begin
            tx_string[15:0] <= {ASC_R, ASC_E};
            tx_length       <= LEN_ER;
          end else if (cmd_kind == CMD_WR) begin
            tx_string[15:0] <= {ASC_K, ASC_O};
            tx_length       <= LEN_OK;
          end else if (cmd_kind == CMD_RD) begin
            tx_string[71:0] <= {rd_hex, ASC_D};
            tx_length       <= LEN_DATA;
          end else begin
            tx_string[31:0] <= {ASC_G, ASC_N, ASC_O, ASC_P};
            tx_length       <= LEN_PONG;
          end
        end
        ST_SEND:      tmo_cnt <= '0;
        ST_WAIT_DONE: tmo_cnt <= tmo_cnt + TMO_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - directed scoreboard bench for uart_cmd_responder
module tb_uart_cmd_responder;

  localparam int NUM_REGS = 16;
  localparam int TMO      = 1000;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [1023:0] rx_string = '0;
  logic [7:0]    rx_length = '0;
  logic          rx_done = 1'b0;
  logic [1023:0] tx_string;
  logic [7:0]    tx_length;
  logic          tx_req;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic [7:0]    reg_addr;
  logic          reg_wr_en;
  logic [31:0]   reg_wr_data;
  logic          reg_rd_en;
  logic [31:0]   reg_rd_data = 32'h5A5A_5A5A;
  logic          busy;
  logic [7:0]    drop_cnt;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0, rd_cnt = 0, overlap_cnt = 0;
  logic [7:0]    last_addr = '0;
  logic [31:0]   last_wdata = '0;
  logic [31:0]   rd_value = '0;
  logic [1023:0] exp_str_q[$];
  logic [7:0]    exp_len_q[$];
  logic [1023:0] last_exp = '0;

  uart_cmd_responder #(.NUM_REGS(NUM_REGS), .TX_TIMEOUT_CLKS(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .rx_string(rx_string), .rx_length(rx_length), .rx_done(rx_done),
    .tx_string(tx_string), .tx_length(tx_length), .tx_req(tx_req),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // register slave: data valid for exactly the one clock after the read strobe
  always @(posedge sys_clk) begin
    if (reg_rd_en) begin #1 reg_rd_data = rd_value; end
    else begin #1 reg_rd_data = 32'h5A5A_5A5A; end
  end

  always @(negedge sys_clk) begin
    if (reg_wr_en) begin wr_cnt++; last_addr = reg_addr; last_wdata = reg_wr_data; end
    if (reg_rd_en) begin rd_cnt++; last_addr = reg_addr; end
    if (reg_wr_en && reg_rd_en) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] str2bits(input string s);
    logic [1023:0] b;
    b = '0;
    for (int k = 0; k < s.len(); k++) b[8*k +: 8] = s[k];
    return b;
  endfunction

  task automatic expect_reply(input string s);
    exp_str_q.push_back(str2bits(s));
    exp_len_q.push_back(8'(s.len()));
  endtask

  task automatic send_cmd(input string s);
    @(posedge sys_clk); #1;
    rx_string = str2bits(s);
    rx_length = 8'(s.len());
    rx_done   = 1'b1;
    @(posedge sys_clk); #1;
    rx_done   = 1'b0;
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    do begin @(negedge sys_clk); n++; end while (tx_req !== 1'b1 && n < 100);
    chk({tag, " tx_req"}, tx_req, 1'b1);
    chk({tag, " pending"}, exp_str_q.size(), 1);
    if (exp_str_q.size() > 0) begin
      last_exp = exp_str_q.pop_front();
      chk({tag, " tx_string"}, tx_string, last_exp);
      chk({tag, " tx_length"}, tx_length, exp_len_q.pop_front());
    end
  endtask

  task automatic finish_reply(input string tag, input logic collide);
    @(negedge sys_clk);
    chk({tag, " tx_req_one_cycle"}, tx_req, 1'b0);
    chk({tag, " tx_string_stable"}, tx_string, last_exp);
    @(posedge sys_clk); #1;
    tx_done = 1'b1;
    rx_done = collide;
    @(posedge sys_clk); #1;
    tx_done = 1'b0;
    rx_done = 1'b0;
    @(negedge sys_clk);
    chk({tag, " idle"}, busy, 1'b0);
  endtask

  task automatic do_cmd(input string tag, input string cmd, input string reply,
                        input int exp_wr, input int exp_rd);
    int wr0, rd0, n;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    expect_reply(reply);
    send_cmd(cmd);
    wait_req(tag, n);
    finish_reply(tag, 1'b0);
    chk({tag, " wr_strobes"}, wr_cnt - wr0, exp_wr);
    chk({tag, " rd_strobes"}, rd_cnt - rd0, exp_rd);
  endtask

  initial begin
    int n, req_seen, wr0;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset outputs", {busy, tx_req, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, tx_length, drop_cnt}, '0);
    chk("reset tx_string", tx_string, '0);
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;

    do_cmd("w03", "W0312345678", "OK", 1, 0);
    chk("w03 addr", last_addr, 8'h03);
    chk("w03 data", last_wdata, 32'h1234_5678);

    rd_value = 32'hDEAD_BEEF;
    do_cmd("r03", "R03", "DDEADBEEF", 0, 1);
    chk("r03 addr", last_addr, 8'h03);

    do_cmd("w0f_lower", "W0Fabcdef01", "OK", 1, 0);
    chk("w0f addr", last_addr, 8'h0F);
    chk("w0f data", last_wdata, 32'hABCD_EF01);

    rd_value = 32'h0123_A5C9;
    do_cmd("r0f_lower", "R0f", "D0123A5C9", 0, 1);
    chk("r0f addr", last_addr, 8'h0F);

    do_cmd("r10_range", "R10", "ER", 0, 0);
    do_cmd("w_badhex", "W0G00000000", "ER", 0, 0);
    do_cmd("unknown_x", "X", "ER", 0, 0);
    do_cmd("len0", "", "ER", 0, 0);
    do_cmd("w_short", "W031234567", "ER", 0, 0);
    do_cmd("r_long", "R033", "ER", 0, 0);
`ifdef UART_CMD_PING_EN
    do_cmd("ping", "P", "PONG", 0, 0);
`else
    do_cmd("ping", "P", "ER", 0, 0);
`endif

    rd_value = 32'h89AB_CDEF;
    wr0 = wr_cnt;
    expect_reply("D89ABCDEF");
    send_cmd("R01");
    wait_req("drop", n);
    send_cmd("W0100000000");
    @(negedge sys_clk);
    chk("drop first", drop_cnt, 8'd1);
    finish_reply("drop collide", 1'b1);
    chk("drop collide cnt", drop_cnt, 8'd2);
    @(negedge sys_clk);
    chk("drop collide no start", busy, 1'b0);
    chk("drop no write", wr_cnt - wr0, 0);

    tx_busy  = 1'b1;
    rd_value = 32'h0000_0007;
    expect_reply("D00000007");
    send_cmd("R02");
    req_seen = 0;
    repeat (500) begin @(negedge sys_clk); if (tx_req) req_seen++; end
    chk("busy_hold tx_req", req_seen, 0);
    chk("busy_hold busy", busy, 1'b1);
    @(posedge sys_clk); #1 tx_busy = 1'b0;
    wait_req("busy_release", n);
    chk("busy_release latency", n, 1);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
      rx_done = (n <= 520) && n[0];
    end while (busy && n < 3*TMO);
    rx_done = 1'b0;
    chk("timeout window", (n >= TMO) && (n <= TMO + 2), 1'b1);
    chk("drop saturate", drop_cnt, 8'hFF);

    wr0 = wr_cnt;
    send_cmd("W0312345678");
    @(posedge sys_clk); #1;
    chk("mid_parse busy", busy, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_parse reset outputs", {busy, tx_req, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, tx_length, drop_cnt}, '0);
    chk("mid_parse reset tx_string", tx_string, '0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("mid_parse not resumed", {busy, 32'(wr_cnt - wr0)}, '0);

    rd_value = 32'hCAFE_F00D;
    do_cmd("r05_after_reset", "R05", "DCAFEF00D", 0, 1);
    chk("strobe overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
